// File: rtl/rbm_pkg.sv
// Shared definitions for the RBM label voter: FSM state encoding and the
// clog2 helper used to derive counter and index widths.
package rbm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESTART = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_SCAN    = 3'd4,
    ST_DONE    = 3'd5
  } voter_state_e;

  // Ceiling log2; clog2(1) = 0. Only evaluated on elaboration constants.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rbm_argmax_scan.sv
// Sequential argmax: one candidate per step, strict greater-than update so
// ties resolve to the lowest index seen first.
module rbm_argmax_scan #(
  parameter int value_w = 5,
  parameter int idx_w   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               step,
  input  logic [value_w-1:0] value,
  output logic [idx_w-1:0]   idx,
  output logic [idx_w-1:0]   best_idx,
  output logic [value_w-1:0] best_val
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else if (clear) begin
      idx      <= '0;
      best_idx <= '0;
      best_val <= '0;
    end else if (step) begin
      // best starts at 0, so an all-zero vote keeps index 0
      if (value > best_val) begin
        best_val <= value;
        best_idx <= idx;
      end
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/rbm_label_voter.sv
// Majority-vote classifier over repeated RBM label-layer samples.
// Optional `confidence` output (winning count) enabled by RBM_VOTER_CONFIDENCE_EN.
module rbm_label_voter
  import rbm_pkg::*;
#(
  parameter int output_dim = 10,
  parameter int sample_num = 16,
  localparam int count_bitlength = clog2(sample_num + 1),
  localparam int label_bitlength = (clog2(output_dim) < 1) ? 1 : clog2(output_dim)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       layer_finish,
  input  logic [output_dim-1:0]      InputData,
  output logic                       layer_restart,
  output logic                       busy,
  output logic [label_bitlength-1:0] label,
  output logic                       label_valid,
`ifdef RBM_VOTER_CONFIDENCE_EN
  output logic [count_bitlength-1:0] confidence,
`endif
  output voter_state_e               state_dbg
);

  // Handshake: label_valid is a one-cycle strobe with no back-pressure;
  // label (and confidence) are valid while it is high and held afterwards.

  voter_state_e                state, state_nxt;
  logic                        finish_d;
  logic                        finish_rise;
  logic [count_bitlength-1:0]  count [output_dim];
  logic [count_bitlength-1:0]  sample_cnt;
  logic [label_bitlength-1:0]  label_q;
  logic [label_bitlength-1:0]  scan_idx;
  logic [label_bitlength-1:0]  best_idx;
  logic [count_bitlength-1:0]  best_val;
  logic                        scan_clear;
  logic                        scan_step;
  logic                        scan_last;
  logic                        accum_last;

  assign finish_rise = layer_finish & ~finish_d;
  assign accum_last  = (sample_cnt == count_bitlength'(sample_num - 1));
  assign scan_last   = (scan_idx == label_bitlength'(output_dim - 1));
  assign state_dbg   = state;

  always_comb begin
    state_nxt     = state;
    layer_restart = 1'b0;
    busy          = (state != ST_IDLE);
    label_valid   = 1'b0;
    scan_clear    = 1'b0;
    scan_step     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          scan_clear = 1'b1;
          state_nxt  = ST_RESTART;
        end
      end
      ST_RESTART: begin
        layer_restart = 1'b1;
        state_nxt     = ST_WAIT;
      end
      ST_WAIT: begin
        if (finish_rise) state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        state_nxt = accum_last ? ST_SCAN : ST_RESTART;
      end
      ST_SCAN: begin
        scan_step = 1'b1;
        if (scan_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        label_valid = 1'b1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      finish_d   <= 1'b0;
      sample_cnt <= '0;
      label_q    <= '0;
      for (int k = 0; k < output_dim; k++) count[k] <= '0;
    end else begin
      state    <= state_nxt;
      finish_d <= layer_finish;
      if (state == ST_IDLE && start) begin
        sample_cnt <= '0;
        for (int k = 0; k < output_dim; k++) count[k] <= '0;
      end else if (state == ST_ACCUM) begin
        sample_cnt <= sample_cnt + 1'b1;
        for (int k = 0; k < output_dim; k++) begin
          count[k] <= count[k] + count_bitlength'(InputData[k]);
        end
      end
      if (state == ST_DONE) label_q <= best_idx;
    end
  end

  // The scan result is final by DONE, so it is forwarded during that cycle.
  assign label = (state == ST_DONE) ? best_idx : label_q;

`ifdef RBM_VOTER_CONFIDENCE_EN
  logic [count_bitlength-1:0] conf_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conf_q <= '0;
    end else if (state == ST_DONE) begin
      conf_q <= best_val;
    end
  end

  assign confidence = (state == ST_DONE) ? best_val : conf_q;
`endif

  rbm_argmax_scan #(
    .value_w (count_bitlength),
    .idx_w   (label_bitlength)
  ) u_scan (
    .clock    (clock),
    .reset    (reset),
    .clear    (scan_clear),
    .step     (scan_step),
    .value    (count[scan_idx]),
    .idx      (scan_idx),
    .best_idx (best_idx),
    .best_val (best_val)
  );

endmodule

// File: tb/tb_rbm_label_voter.sv
// Scoreboard bench for rbm_label_voter (output_dim=4, sample_num=4) with a
// behavioural label-layer model that raises finish 5 cycles after each restart.
module tb_rbm_label_voter;
  import rbm_pkg::*;

  localparam int OD = 4;
  localparam int SN = 4;
  localparam int CW = 3;
  localparam int LW = 2;
  localparam int W  = CW + LW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          layer_finish = 1'b0;
  logic [OD-1:0] in_data = '0;
  logic          layer_restart;
  logic          busy;
  logic [LW-1:0] label;
  logic          label_valid;
  logic [CW-1:0] confidence;
  voter_state_e  state_dbg;

`ifndef RBM_VOTER_CONFIDENCE_EN
  assign confidence = '0;
`endif

  rbm_label_voter #(
    .output_dim (OD),
    .sample_num (SN)
  ) dut (
    .clock         (clk),
    .reset         (rst_n),
    .start         (start),
    .layer_finish  (layer_finish),
    .InputData     (in_data),
    .layer_restart (layer_restart),
    .busy          (busy),
    .label         (label),
    .label_valid   (label_valid),
`ifdef RBM_VOTER_CONFIDENCE_EN
    .confidence    (confidence),
`endif
    .state_dbg     (state_dbg)
  );

  // ---------------- shared bench state ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int restart_cnt = 0;
  int rise_num = 0;
  int last_rise_cyc = 0;
  int hold_req = 0;
  bit rand_mode = 1'b0;
  logic [W-1:0]  exp_q[$];
  logic [OD-1:0] sample_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- label-layer model ----------------
  int rise_cnt = 0;
  int hold_cnt = 0;
  bit pending = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rise_cnt = 0;
      hold_cnt = 0;
      pending  = 1'b0;
      if (rand_mode) begin
        layer_finish = 1'($urandom_range(0, 1));
        in_data      = OD'($urandom_range(0, 15));
      end else begin
        layer_finish = 1'b0;
        in_data      = '0;
      end
    end else if (layer_restart) begin
      if (hold_cnt > 0) begin
        pending = 1'b1;
      end else begin
        layer_finish = 1'b0;
        rise_cnt     = 5;
      end
    end else if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) begin
        layer_finish = 1'b0;
        if (pending) begin
          pending  = 1'b0;
          rise_cnt = 5;
        end
      end
    end else if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin
        layer_finish  = 1'b1;
        in_data       = (sample_q.size() > 0) ? sample_q.pop_front() : '0;
        last_rise_cyc = cyc;
        rise_num++;
        if (hold_req > 0) begin
          hold_cnt = hold_req;
          hold_req = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit prev_lv = 1'b0;
  logic [W-1:0] exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      restart_cnt = 0;
      prev_lv     = 1'b0;
    end else begin
      if (layer_restart) restart_cnt++;
      if (prev_lv) check("label_valid_one_cycle", label_valid, 0);
      if (label_valid && !prev_lv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_label_valid", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("label", label, exp_v[LW-1:0]);
`ifdef RBM_VOTER_CONFIDENCE_EN
          check("confidence", confidence, exp_v[W-1:LW]);
`endif
          check("restarts_per_run", restart_cnt, SN);
          check("valid_latency", cyc - last_rise_cyc, 6);
        end
        restart_cnt = 0;
        done_cnt++;
      end
      prev_lv = label_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int target);
    for (int i = 0; i < 500 && done_cnt < target; i++) @(negedge clk);
    check("run_complete", done_cnt, target);
  endtask

  task automatic run_vote(input logic [OD-1:0] s0, input logic [OD-1:0] s1,
                          input logic [OD-1:0] s2, input logic [OD-1:0] s3,
                          input logic [LW-1:0] exp_lbl, input logic [CW-1:0] exp_conf,
                          input int hold, input bit poke_start);
    int target;
    sample_q.push_back(s0);
    sample_q.push_back(s1);
    sample_q.push_back(s2);
    sample_q.push_back(s3);
    hold_req = hold;
    exp_q.push_back({exp_conf, exp_lbl});
    target = done_cnt + 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("restart_after_start", layer_restart, 1);
    check("busy_after_start", busy, 1);
    if (poke_start) begin
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    wait_done(target);
    repeat (3) @(negedge clk);
    check("busy_back_idle", busy, 0);
    check("label_held", label, exp_lbl);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    // reset held with random inputs
    rand_mode = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      #1;
      check("rst_busy", busy, 0);
      check("rst_layer_restart", layer_restart, 0);
      check("rst_label", label, 0);
      check("rst_label_valid", label_valid, 0);
`ifdef RBM_VOTER_CONFIDENCE_EN
      check("rst_confidence", confidence, 0);
`endif
    end
    start = 1'b0;
    rand_mode = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("idle_no_restart", restart_cnt, 0);
    check("idle_busy", busy, 0);

    // unanimous vote for unit 2
    run_vote(4'b0100, 4'b0100, 4'b0100, 4'b0100, 2'd2, 3'd4, 0, 1'b0);
    // tie between units 0 and 1 resolves to the lower index
    run_vote(4'b0011, 4'b0011, 4'b0001, 4'b0010, 2'd0, 3'd3, 0, 1'b0);
    // first finish held for 20 cycles, extra start while busy
    run_vote(4'b0001, 4'b0010, 4'b0010, 4'b0100, 2'd1, 3'd2, 20, 1'b1);

    // reset after the second accumulation: run aborted silently
    sample_q.push_back(4'b0001);
    sample_q.push_back(4'b0001);
    sample_q.push_back(4'b0001);
    sample_q.push_back(4'b0001);
    base = rise_num;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 200 && rise_num < base + 2; i++) @(negedge clk);
    check("mid_run_progress", rise_num - base, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_label", label, 0);
      check("abort_label_valid", label_valid, 0);
    end
    sample_q.delete();
    base = done_cnt;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_valid", done_cnt, base);

    run_vote(4'b1000, 4'b1000, 4'b1000, 4'b1000, 2'd3, 3'd4, 0, 1'b0);
    run_vote(4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 3'd0, 0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rbm_label_voter.md
# rbm_label_voter

- Downstream consumer of the RBM label layer.
- Repeatedly restarts the layer, collects `sample_num` stochastic binary output vectors, and counts ones per output unit.
- Reports the unit with the highest count as the classification label.
- Turns the per-run Bernoulli samples into a stable majority-vote decision for the top of the network.

## Interface

Parameters:
- `output_dim`, 10, number of label units; width of the sampled vector.
- `sample_num`, 16, samples accumulated per classification; must be ≥1.
- `count_bitlength`, derived localparam, clog2(`sample_num`+1); per-unit counter width.
- `label_bitlength`, derived localparam, clog2(`output_dim`), minimum 1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clock` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low; clears all state.
- `start` input 1: one-cycle request to begin a classification; honoured only in IDLE.
- `layer_finish` input 1: connected to the layer's `finish` level.
- `InputData` input `output_dim`: connected to the layer's `OutputData`; valid while `layer_finish`=1.
- `layer_restart` output 1: one-cycle active-high pulse wired to the layer's `reset`; the layer's `rand_reset` is not driven.
- `busy` output 1: high in every state except IDLE.
- `label` output `label_bitlength`: winning unit index; held until the next `start`.
- `label_valid` output 1: one-cycle pulse when `label` is updated.

## Operation

FSM states: IDLE, RESTART, WAIT, ACCUM, SCAN, DONE.
- IDLE: `start`=1 → clear all counters and `sample_cnt` → RESTART.
- RESTART: `layer_restart`=1 for exactly this cycle → WAIT.
- WAIT: a rising edge of `layer_finish` (registered copy `finish_d`; edge = `layer_finish` & !`finish_d`) → ACCUM. A level held high without an edge is never counted.
- ACCUM: for each k, `count[k]` += `InputData[k]`. `sample_cnt`++.
  - If the post-increment `sample_cnt` == `sample_num` → SCAN.
  - Otherwise → RESTART.
- SCAN: sequential argmax over one unit per cycle, idx 0..`output_dim`-1.
  - Replace `best` only on strict greater-than, so ties resolve to the lowest index.
  - After idx `output_dim`-1 → DONE.
- DONE: load `label` ← `best_idx`, pulse `label_valid` → IDLE.

Rules:
- Counters never overflow: max count = `sample_num`, which fits `count_bitlength`.
- `start` in any non-IDLE state is ignored and not queued.
- `start` coincident with DONE is ignored.

## Timing

- Reset values: `layer_restart`=0, `busy`=0, `label`=0, `label_valid`=0. All counters are 0 and state is IDLE.
- `start` sampled high at cycle t → RESTART at t+1, with `layer_restart` high during t+1. WAIT starts at t+2.
- Edge seen at cycle e → ACCUM at e+1.
  - `InputData` is sampled at e+1.
  - `layer_restart` for the next sample is asserted at e+2.
- Final ACCUM at cycle a:
  - SCAN occupies a+1 .. a+`output_dim`.
  - DONE at a+`output_dim`+1; `label`/`label_valid` are visible from that cycle.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No `label_valid` is issued for the aborted run.

## Configuration

- `RBM_VOTER_CONFIDENCE_EN` defined: adds output `confidence` [`count_bitlength`-1:0].
  - Equals the winning count.
  - Updated in DONE together with `label`; reset value 0.
- Undefined: the port and its register are absent. All other behaviour and timing are identical.

## Structure

- Shared package `rbm_pkg` holds:
  - FSM state encodings.
  - The clog2 helper used for derived widths.
- Natural sub-module: `rbm_argmax_scan`.
  - Holds the sequential index/best-value comparator.
  - Ports: clear, step, value, idx out, best out.
- Counters, FSM and edge detection stay in the top module.

## Test plan

Bench configuration: `output_dim`=4, `sample_num`=4. A bench model drives `layer_finish` rising 5 cycles after each `layer_restart`.

- Reset: hold `reset`=0 with random inputs → all outputs 0, `busy`=0. Release; no activity without `start`.
- Unanimous: four samples of 4'b0100 → `label`=2, `label_valid` one cycle at a+5, `confidence`=4 (with `RBM_VOTER_CONFIDENCE_EN`).
- Tie: samples 0011, 0011, 0001, 0010 → counts [3,3,0,0] → `label`=0, `confidence`=3.
- Held finish / ignored start:
  - Keep `layer_finish` high for 20 cycles → exactly one accumulation.
  - Pulse `start` while `busy` → no restart of the run.
  - Exactly 4 `layer_restart` pulses per run.
- Reset mid-run: assert `reset` after the 2nd ACCUM → IDLE, no `label_valid`. A following run with four samples of 4'b1000 → `label`=3.
- All-zero samples: four samples of 4'b0000 → `label`=0, `confidence`=0, `label_valid` pulses once.
